// File: rtl/if_fetch_stage_if.sv
// Instruction-bus interface between the fetch stage (master) and the instruction memory (slave).
// A request is accepted in any cycle where inst_req and inst_addr_ok are both high; exactly one
// inst_data_ok pulse, carrying inst_rdata, returns later for each accepted request, in order.
interface if_fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// PC generator and instruction-fetch stage: issues one bus request at a time, buffers the returned
// word, and hands {pc, inst} to decode through the IF/ID latch, with branch and flush redirection.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                   cpu_clk_75M,
    input  logic                   cpu_rst_n,
    input  logic [5:0]             stall,
    input  logic                   flush_i,
    input  logic [31:0]            new_pc_i,
    input  logic                   branch_flag_i,
    input  logic [31:0]            branch_target_i,
    if_fetch_stage_if.master       ibus,
    output logic                   stop_from_if,
    output logic [31:0]            id_pc_o,
    output logic [31:0]            id_inst_o,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_DROP  = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ibuf_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_inst_q;
    logic [31:0] pc_d;
    logic        advance;
    logic        unused_stall;

    assign unused_stall = ^stall[5:3];

    // Stop depends only on state and flush so the controller sees no loop through stall.
    assign ibus.inst_req  = cpu_rst_n && (state_q == S_FETCH) && !flush_i;
    assign ibus.inst_addr = pc_q;
    assign stop_from_if   = cpu_rst_n && (state_q != S_READY) && !flush_i;

    assign advance = (state_q == S_READY) && !stall[0];
    assign pc_d    = branch_flag_i ? branch_target_i : pc_q + 32'd4;

    assign id_pc_o     = id_pc_q;
    assign id_inst_o   = id_inst_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ibuf_q    <= 32'd0;
            id_pc_q   <= 32'd0;
            id_inst_q <= NOP_INST;
        end else if (flush_i) begin
            pc_q      <= new_pc_i;
            id_pc_q   <= 32'd0;
            id_inst_q <= NOP_INST;
            // An in-flight response must still be drained before refetching.
            case (state_q)
                S_WAIT, S_DROP: state_q <= ibus.inst_data_ok ? S_FETCH : S_DROP;
                default:        state_q <= S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ibus.inst_addr_ok) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (ibus.inst_data_ok) begin
                        ibuf_q  <= ibus.inst_rdata;
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    if (!stall[0]) begin
                        pc_q    <= pc_d;
                        state_q <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (ibus.inst_data_ok) state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase

            if (advance) begin
                id_pc_q   <= pc_q;
                id_inst_q <= ibuf_q;
            end else if (!(stall[1] && stall[2])) begin
                id_pc_q   <= 32'd0;
                id_inst_q <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br;
  logic [31:0] tgt;
  logic        stop;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) dut (
    .cpu_clk_75M     (clk),
    .cpu_rst_n       (rst_n),
    .stall           (stall),
    .flush_i         (flush),
    .new_pc_i        (new_pc),
    .branch_flag_i   (br),
    .branch_target_i (tgt),
    .ibus            (bus.master),
    .stop_from_if    (stop),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst),
    .dbg_state_o     (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model: pc, whether a buffered word is waiting to advance, whether a bus request is
  // outstanding, and whether that outstanding response is to be thrown away.
  logic [31:0] m_pc;
  logic [31:0] m_ibuf;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  bit          m_have;
  bit          m_out;
  bit          m_disc;

  // Bus slave: accepted addresses wait in exp_q; the word returned is ~address.
  logic [31:0] exp_q[$];
  int          s_cnt;
  int          lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ibuf = 32'd0;
    m_id_pc = 32'd0;
    m_id_inst = NOP_INST;
    m_have = 0;
    m_out = 0;
    m_disc = 0;
    exp_q.delete();
    s_cnt = 0;
  endtask

  task automatic idle_inputs();
    stall = 6'h03;
    flush = 1'b0;
    new_pc = 32'd0;
    br = 1'b0;
    tgt = 32'd0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata = 32'd0;
  endtask

  task automatic step(input logic [5:0] st, input logic fl, input logic [31:0] npc,
                      input logic b, input logic [31:0] bt, input logic aok);
    logic        dok;
    logic [31:0] rd;
    logic        exp_req;
    logic        exp_stop;
    logic        acc;
    logic        adv;
    logic        bus_acc;
    logic [31:0] bus_addr;
    @(negedge clk);
    stall = st;
    flush = fl;
    new_pc = npc;
    br = b;
    tgt = bt;
    bus.inst_addr_ok = aok;
    dok = (exp_q.size() != 0) && (s_cnt == 0);
    rd = dok ? ~exp_q[0] : $urandom;
    bus.inst_data_ok = dok;
    bus.inst_rdata = rd;
    #1;
    exp_req = !m_have && !m_out && !fl;
    exp_stop = !m_have && !fl;
    check("inst_req", {31'd0, bus.inst_req}, {31'd0, exp_req});
    check("inst_addr", bus.inst_addr, m_pc);
    check("stop_from_if", {31'd0, stop}, {31'd0, exp_stop});
    check("id_pc_o", id_pc, m_id_pc);
    check("id_inst_o", id_inst, m_id_inst);
    bus_acc = bus.inst_req && aok;
    bus_addr = bus.inst_addr;

    acc = exp_req && aok;
    adv = m_have && !st[0] && !fl;
    if (fl) begin
      m_id_pc = 32'd0;
      m_id_inst = NOP_INST;
    end else if (adv) begin
      m_id_pc = m_pc;
      m_id_inst = m_ibuf;
    end else if (!(st[1] && st[2])) begin
      m_id_pc = 32'd0;
      m_id_inst = NOP_INST;
    end
    if (fl) begin
      m_pc = npc;
      m_have = 0;
      if (dok) begin
        m_out = 0;
        m_disc = 0;
      end else if (m_out) begin
        m_disc = 1;
      end
    end else begin
      if (dok) begin
        m_out = 0;
        if (!m_disc) begin
          m_have = 1;
          m_ibuf = rd;
        end
        m_disc = 0;
      end
      if (adv) begin
        m_pc = b ? bt : m_pc + 32'd4;
        m_have = 0;
      end
      if (acc) m_out = 1;
    end

    @(posedge clk);
    if (dok) void'(exp_q.pop_front());
    else if (exp_q.size() != 0) s_cnt--;
    if (bus_acc) begin
      exp_q.push_back(bus_addr);
      s_cnt = lat;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst inst_req", {31'd0, bus.inst_req}, 32'd0);
    check("rst stop_from_if", {31'd0, stop}, 32'd0);
    check("rst id_pc_o", id_pc, 32'd0);
    check("rst id_inst_o", id_inst, NOP_INST);
    check("rst inst_addr", bus.inst_addr, RESET_PC);
  endtask

  initial begin
    logic [5:0]  st;
    logic        fl;
    int          fl_left;
    int          n;
    idle_inputs();
    model_reset();
    lat = 0;
    fl_left = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait bus: one instruction every three cycles.
    repeat (3) step(m_have ? 6'h00 : 6'h03, 0, 32'd0, 0, 32'd0, 1);
    #1;
    check("seq addr 2", bus.inst_addr, 32'hBFC0_0004);
    check("seq id_pc 1", id_pc, 32'hBFC0_0000);
    check("seq id_inst 1", id_inst, 32'h403F_FFFF);
    repeat (3) step(m_have ? 6'h00 : 6'h03, 0, 32'd0, 0, 32'd0, 1);
    #1;
    check("seq addr 3", bus.inst_addr, 32'hBFC0_0008);
    check("seq id_inst 2", id_inst, 32'h403F_FFFB);

    // Taken branch resolved while the delay slot advances.
    repeat (2) step(6'h03, 0, 32'd0, 0, 32'd0, 1);
    step(6'h00, 0, 32'd0, 1, 32'h8000_1000, 1);
    #1;
    check("branch addr", bus.inst_addr, 32'h8000_1000);
    check("branch id_pc", id_pc, 32'hBFC0_0008);

    // Hold in READY for four cycles, then one advance.
    repeat (2) step(6'h03, 0, 32'd0, 0, 32'd0, 1);
    repeat (4) step(6'h1F, 0, 32'd0, 0, 32'd0, 1);
    step(6'h00, 0, 32'd0, 0, 32'd0, 1);
    #1;
    check("stall addr", bus.inst_addr, 32'h8000_1004);
    check("stall id_pc", id_pc, 32'h8000_1000);
    check("stall id_inst", id_inst, 32'h7FFF_EFFF);

    // Flush while waiting; response arrives two cycles later and is dropped.
    lat = 2;
    step(6'h03, 0, 32'd0, 0, 32'd0, 1);
    step(6'h03, 1, 32'h8000_0180, 0, 32'd0, 0);
    repeat (2) step(6'h03, 0, 32'd0, 0, 32'd0, 0);
    #1;
    check("drop addr", bus.inst_addr, 32'h8000_0180);
    check("drop id_inst", id_inst, NOP_INST);
    check("drop id_pc", id_pc, 32'd0);

    // Two-cycle flush in FETCH with the slave offering accept both cycles.
    lat = 0;
    step(6'h03, 1, 32'h8000_0200, 0, 32'd0, 1);
    step(6'h03, 1, 32'h8000_0300, 0, 32'd0, 1);
    #1;
    check("flush2 addr", bus.inst_addr, 32'h8000_0300);
    check("flush2 id_inst", id_inst, NOP_INST);
    repeat (3) step(m_have ? 6'h00 : 6'h03, 0, 32'd0, 0, 32'd0, 1);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      lat = $urandom_range(0, 5);
      if (fl_left > 0) begin
        fl = 1;
        fl_left--;
      end else if ($urandom_range(0, 13) == 0) begin
        fl = 1;
        fl_left = $urandom_range(0, 1);
      end else begin
        fl = 0;
      end
      n = $urandom_range(0, 5);
      if (!m_have && n < 2) n = 2;
      st = 6'h3F >> (6 - n);
      step(st, fl, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0),
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
